// File: rtl/moore_seq_pkg.sv
// rtl/moore_seq_pkg.sv - shared helpers for the parametrised Moore sequence detector
package moore_seq_pkg;

    localparam logic MODE_NONOVL = 1'b0;
    localparam logic MODE_OVL    = 1'b1;

    function automatic int state_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int clamp_len(input int l, input int n);
        if (l < 1) begin
            return 1;
        end
        if (l > n) begin
            return n;
        end
        return l;
    endfunction

    function automatic logic len_in_range(input int l, input int n);
        return (l >= 1) && (l <= n);
    endfunction

endpackage

// File: rtl/seq_next_state.sv
// rtl/seq_next_state.sv - combinational KMP-style next-state for a runtime pattern
module seq_next_state
    import moore_seq_pkg::*;
#(
    parameter int N  = 8,
    parameter int SW = state_w(N)
) (
    input  logic [SW-1:0] s,
    input  logic          b,
    input  logic [N-1:0]  pattern,
    input  logic [SW-1:0] len,
    input  logic          overlap,
    output logic [SW-1:0] next_state
);

    localparam int TW = N + 1;

    function automatic logic [TW-1:0] low_mask(input logic [SW:0] n);
        return (TW'(1) << n) - TW'(1);
    endfunction

    logic [TW-1:0] t;
    logic [TW-1:0] pat_x;
    logic [TW-1:0] mk;
    logic [SW:0]   k_w;
    logic [SW:0]   sh;
    logic          found;

    // t holds the consumed string pattern[0..s-1] followed by b; the loop looks
    // for the longest pattern prefix that is a suffix of t.
    always_comb begin
        next_state = '0;
        found      = 1'b0;
        k_w        = '0;
        sh         = '0;
        mk         = '0;
        pat_x      = {1'b0, pattern};
        t          = (pat_x & low_mask({1'b0, s})) | (TW'(b) << s);
        if ((s == len) && (overlap == MODE_NONOVL)) begin
            next_state = (b == pattern[0]) ? SW'(1) : '0;
        end else begin
            for (int k = N; k >= 1; k--) begin
                k_w = (SW + 1)'(k);
                if (!found && (k_w <= {1'b0, s} + 1'b1) && (k_w <= {1'b0, len})) begin
                    sh = {1'b0, s} + 1'b1 - k_w;
                    mk = low_mask(k_w);
                    if (((t >> sh) & mk) == (pat_x & mk)) begin
                        next_state = k_w[SW-1:0];
                        found      = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/moore_seq_detector_param.sv
// rtl/moore_seq_detector_param.sv - runtime-configurable Moore serial pattern detector
module moore_seq_detector_param
    import moore_seq_pkg::*;
#(
    parameter int         N           = 8,
    parameter int         CNT_W       = 8,
    parameter logic [N-1:0] DEF_PATTERN = N'(8'b0000_0101),
    parameter int         DEF_LEN     = 4,
    parameter logic       DEF_OVERLAP = 1'b1,
    localparam int        SW          = state_w(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             data_in,
    input  logic             cfg_load,
    input  logic [N-1:0]     cfg_pattern,
    input  logic [SW-1:0]    cfg_len,
    input  logic             cfg_overlap,
    output logic             y,
    output logic [SW-1:0]    state_o,
    output logic [CNT_W-1:0] match_count,
    output logic             cfg_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [N-1:0]  pattern_q;
    logic [SW-1:0] len_q;
    logic          overlap_q;
    logic [SW-1:0] state_q;
    logic [SW-1:0] next_state;

    seq_next_state #(
        .N  (N),
        .SW (SW)
    ) u_next (
        .s          (state_q),
        .b          (data_in),
        .pattern    (pattern_q),
        .len        (len_q),
        .overlap    (overlap_q),
        .next_state (next_state)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            pattern_q   <= DEF_PATTERN;
            len_q       <= SW'(clamp_len(DEF_LEN, N));
            overlap_q   <= DEF_OVERLAP;
            state_q     <= '0;
            y           <= 1'b0;
            match_count <= '0;
            cfg_err     <= 1'b0;
        end else if (cfg_load) begin
            pattern_q   <= cfg_pattern;
            len_q       <= SW'(clamp_len(int'(cfg_len), N));
            overlap_q   <= cfg_overlap;
            cfg_err     <= !len_in_range(int'(cfg_len), N);
            state_q     <= '0;
            y           <= 1'b0;
            match_count <= '0;
        end else if (en) begin
            state_q <= next_state;
            y       <= (next_state == len_q);
            if ((next_state == len_q) && (match_count != CNT_MAX)) begin
                match_count <= match_count + 1'b1;
            end
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_moore_seq_detector_param.sv
// tb/tb_moore_seq_detector_param.sv - self-checking bench for moore_seq_detector_param
module tb_moore_seq_detector_param;

    typedef struct {
        bit         rstn;
        bit         en;
        bit         d;
        bit         ld;
        logic [7:0] pat;
        logic [3:0] len;
        bit         ovl;
        int         st;
        bit         y;
        int         cnt;
        bit         err;
    } vec_t;

    typedef struct {
        int st;
        bit y;
        int cnt;
        int cnt2;
        bit err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       data_in = 1'b0;
    logic       cfg_load = 1'b0;
    logic [7:0] cfg_pattern = '0;
    logic [3:0] cfg_len = '0;
    logic       cfg_overlap = 1'b0;
    logic       y, y2;
    logic [3:0] state_o, state2;
    logic [7:0] match_count;
    logic [1:0] cnt2;
    logic       cfg_err, err2;

    int   n_checks = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    moore_seq_detector_param #(.N(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .data_in(data_in), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .y(y), .state_o(state_o), .match_count(match_count), .cfg_err(cfg_err)
    );

    moore_seq_detector_param #(.N(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .data_in(data_in), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .y(y2), .state_o(state2), .match_count(cnt2), .cfg_err(err2)
    );

    task automatic chk(input string name, input int idx, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, req);
        end
    endtask

    function automatic vec_t v(bit rstn, bit e, bit d, bit ld, logic [7:0] pat, logic [3:0] len,
                               bit ovl, int st, bit yy, int cnt, bit err);
        vec_t r;
        r.rstn = rstn; r.en = e; r.d = d; r.ld = ld; r.pat = pat; r.len = len; r.ovl = ovl;
        r.st = st; r.y = yy; r.cnt = cnt; r.err = err;
        return r;
    endfunction

    function automatic vec_t s(bit d, int st, bit yy, int cnt, bit err);
        return v(1, 1, d, 0, 8'h00, 4'd0, 0, st, yy, cnt, err);
    endfunction

    function automatic vec_t hold(bit d, int st, bit yy, int cnt, bit err);
        return v(1, 0, d, 0, 8'h00, 4'd0, 0, st, yy, cnt, err);
    endfunction

    function automatic vec_t ld(logic [7:0] pat, logic [3:0] len, bit ovl, bit err);
        return v(1, 1, 1, 1, pat, len, ovl, 0, 0, 0, err);
    endfunction

    // Brute-force overlapping reference: longest pattern prefix that is a suffix of history.
    function automatic int model_state(input bit h[$], input logic [7:0] p, input int l);
        for (int k = l; k >= 1; k--) begin
            if (k <= h.size()) begin
                bit ok = 1'b1;
                for (int j = 0; j < k; j++) begin
                    if (h[h.size() - k + j] != p[j]) ok = 1'b0;
                end
                if (ok) return k;
            end
        end
        return 0;
    endfunction

    task automatic apply(input vec_t r, input int idx);
        exp_t e;
        exp_t g;
        @(negedge clk);
        rst = r.rstn; en = r.en; data_in = r.d; cfg_load = r.ld;
        cfg_pattern = r.pat; cfg_len = r.len; cfg_overlap = r.ovl;
        e.st = r.st; e.y = r.y; e.cnt = r.cnt; e.err = r.err;
        e.cnt2 = (r.cnt > 3) ? 3 : r.cnt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        g = exp_q.pop_front();
        chk("state_o", idx, int'(state_o), g.st);
        chk("y", idx, int'(y), int'(g.y));
        chk("match_count", idx, int'(match_count), g.cnt);
        chk("cfg_err", idx, int'(cfg_err), int'(g.err));
        chk("match_count_sat2", idx, int'(cnt2), g.cnt2);
    endtask

    task automatic random_run(input int base, input int steps);
        bit         hist[$];
        logic [7:0] p;
        int         l, st, cnt, idx;
        bit         e, d;
        p = 8'($urandom);
        l = $urandom_range(2, 8);
        idx = base;
        apply(ld(p, 4'(l), 1, 0), idx++);
        cnt = 0;
        st = 0;
        for (int i = 0; i < steps; i++) begin
            e = ($urandom_range(0, 4) != 0);
            d = ($urandom_range(0, 1) != 0);
            if (e) begin
                hist.push_back(d);
                st = model_state(hist, p, l);
                if (st == l && cnt < 255) cnt++;
            end
            apply(v(1, e, d, 0, 8'h00, 4'd0, 0, st, (st == l), cnt, 0), idx++);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    initial begin
        tbl.push_back(v(0, 0, 0, 0, 8'h00, 4'd0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 1, 0, 8'h00, 4'd0, 0, 0, 0, 0, 0));
        // default 1,0,1,0 overlapping
        tbl.push_back(s(1, 1, 0, 0, 0));
        tbl.push_back(s(0, 2, 0, 0, 0));
        tbl.push_back(s(1, 3, 0, 0, 0));
        tbl.push_back(s(0, 4, 1, 1, 0));
        tbl.push_back(s(1, 3, 0, 1, 0));
        tbl.push_back(s(0, 4, 1, 2, 0));
        // non-overlapping 1010
        tbl.push_back(ld(8'h05, 4'd4, 0, 0));
        tbl.push_back(s(1, 1, 0, 0, 0));
        tbl.push_back(s(0, 2, 0, 0, 0));
        tbl.push_back(s(1, 3, 0, 0, 0));
        tbl.push_back(s(0, 4, 1, 1, 0));
        tbl.push_back(s(1, 1, 0, 1, 0));
        tbl.push_back(s(0, 2, 0, 1, 0));
        // 1,1,0 with junk in the unused upper pattern bits
        tbl.push_back(ld(8'hEB, 4'd3, 1, 0));
        tbl.push_back(s(1, 1, 0, 0, 0));
        tbl.push_back(s(1, 2, 0, 0, 0));
        tbl.push_back(s(1, 2, 0, 0, 0));
        tbl.push_back(s(0, 3, 1, 1, 0));
        // enable gaps
        tbl.push_back(ld(8'h05, 4'd4, 1, 0));
        tbl.push_back(s(1, 1, 0, 0, 0));
        tbl.push_back(s(0, 2, 0, 0, 0));
        tbl.push_back(hold(1, 2, 0, 0, 0));
        tbl.push_back(hold(0, 2, 0, 0, 0));
        tbl.push_back(hold(1, 2, 0, 0, 0));
        tbl.push_back(s(1, 3, 0, 0, 0));
        tbl.push_back(s(0, 4, 1, 1, 0));
        tbl.push_back(hold(1, 4, 1, 1, 0));
        tbl.push_back(s(1, 3, 0, 1, 0));
        // reset mid-pattern, reset beats cfg_load with a bad length
        tbl.push_back(ld(8'h05, 4'd4, 1, 0));
        tbl.push_back(s(1, 1, 0, 0, 0));
        tbl.push_back(s(0, 2, 0, 0, 0));
        tbl.push_back(s(1, 3, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 1, 8'h00, 4'd0, 0, 0, 0, 0, 0));
        tbl.push_back(s(0, 0, 0, 0, 0));
        // length clamps and counter saturation
        tbl.push_back(ld(8'h01, 4'd0, 1, 1));
        tbl.push_back(s(1, 1, 1, 1, 1));
        tbl.push_back(s(1, 1, 1, 2, 1));
        tbl.push_back(s(1, 1, 1, 3, 1));
        tbl.push_back(s(1, 1, 1, 4, 1));
        tbl.push_back(s(1, 1, 1, 5, 1));
        tbl.push_back(s(0, 0, 0, 5, 1));
        tbl.push_back(ld(8'hFF, 4'd9, 1, 1));
        for (int i = 1; i <= 7; i++) tbl.push_back(s(1, i, 0, 0, 1));
        tbl.push_back(s(1, 8, 1, 1, 1));
        tbl.push_back(s(1, 8, 1, 2, 1));
        tbl.push_back(ld(8'hFF, 4'd8, 0, 0));
        tbl.push_back(s(1, 1, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        random_run(1000, 60);
        random_run(2000, 60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
